// File: rtl/seq_mac_unit_if.sv
// rtl/seq_mac_unit_if.sv - operand/result handshake bundle for seq_mac_unit
interface seq_mac_unit_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   acc_en;
  logic                   acc_clr;
  logic                   signed_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   busy;
  logic                   overflow;

  modport master (
    output in_valid, a, b, acc_en, acc_clr, signed_mode, out_ready,
    input  in_ready, out_valid, product, acc, busy, overflow
  );

  modport slave (
    input  in_valid, a, b, acc_en, acc_clr, signed_mode, out_ready,
    output in_ready, out_valid, product, acc, busy, overflow
  );
endinterface

// File: rtl/seq_mac_unit.sv
// rtl/seq_mac_unit.sv - sequential shift-add multiply-accumulate engine
// Optional macro SIGNED_MODE_EN enables two's-complement operation via signed_mode.
module seq_mac_unit #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+4
) (
  input logic           clk,
  input logic           rst,
  seq_mac_unit_if.slave bus
);
  localparam int PW = 2*WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q;
  logic                 in_ready_q, busy_q, out_valid_q;
  logic [PW-1:0]        product_q, pp_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 ovf_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic                 acc_en_q;
  logic                 sgn;

`ifdef SIGNED_MODE_EN
  logic signed_q;
  assign sgn = signed_q;
`else
  logic unused_signed_mode;
  assign unused_signed_mode = bus.signed_mode;
  assign sgn = 1'b0;
`endif

  logic                 last;
  logic [PW-1:0]        a_ext, addend, pp_d;
  logic [ACC_WIDTH-1:0] prod_ext, acc_d;
  logic [ACC_WIDTH:0]   sum_w;
  logic                 ovf_step;

  assign last = (cnt_q == CW'(WIDTH-1));

  // The multiplier's top bit carries negative weight in signed mode, so its row is subtracted.
  always_comb begin
    a_ext  = sgn ? PW'($signed(a_q)) : PW'(a_q);
    addend = a_ext << cnt_q;
    if (sgn && last) addend = -addend;
    pp_d     = pp_q + (b_q[0] ? addend : '0);
    prod_ext = sgn ? ACC_WIDTH'($signed(pp_d)) : ACC_WIDTH'(pp_d);
    sum_w    = {1'b0, acc_q} + {1'b0, prod_ext};
    acc_d    = sum_w[ACC_WIDTH-1:0];
    ovf_step = sgn ? ((acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                      (acc_d[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                   : sum_w[ACC_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      pp_q        <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_en_q    <= 1'b0;
`ifdef SIGNED_MODE_EN
      signed_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.acc_clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            acc_en_q   <= bus.acc_en;
`ifdef SIGNED_MODE_EN
            signed_q   <= bus.signed_mode;
`endif
            pp_q       <= '0;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          pp_q  <= pp_d;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            product_q <= pp_d;
            if (acc_en_q) begin
              acc_q <= acc_d;
              ovf_q <= ovf_q | ovf_step;
            end
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.acc       = acc_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_seq_mac_unit.sv
// tb/tb_seq_mac_unit.sv - scoreboard bench for seq_mac_unit (WIDTH=8, ACC_WIDTH=20)
// Honours SIGNED_MODE_EN for the signed-operand vectors.
module tb_seq_mac_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   seen = 1'b0;

  typedef struct {
    logic [15:0] p;
    logic [19:0] acc;
    logic        ovf;
    int          acyc;
  } exp_t;
  exp_t sb[$];

  seq_mac_unit_if #(.WIDTH(8), .ACC_WIDTH(20)) bus ();
  seq_mac_unit #(.WIDTH(8), .ACC_WIDTH(20)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard pop per result presentation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", 32'(bus.product), 32'(e.p));
        chk("acc", 32'(bus.acc), 32'(e.acc));
        chk("overflow", 32'(bus.overflow), 32'(e.ovf));
        chk("latency", 32'(cyc - e.acyc), 32'd8);
      end
    end
    if (!bus.out_valid) seen = 1'b0;
  end

  task automatic chk_reset_state();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    chk("rst_acc", 32'(bus.acc), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
  endtask

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic en,
                       input logic clr, input logic sg, input logic [15:0] ep,
                       input logic [19:0] eacc, input logic eovf, input bit push);
    exp_t e;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.a = ia; bus.b = ib; bus.acc_en = en; bus.acc_clr = clr;
    bus.signed_mode = sg; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.acc_clr = 1'b0;
    chk("run_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("run_busy", 32'(bus.busy), 32'd1);
    if (push) begin
      e.p = ep; e.acc = eacc; e.ovf = eovf; e.acyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 40);
    chk("result_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic complete();
    wait_valid();
    if (bus.out_valid) begin
      @(posedge clk); #1;
      chk("idle_after_handshake", 32'(bus.in_ready), 32'd1);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.acc_clr = 1'b1;
    @(posedge clk); #1;
    bus.acc_clr = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.acc_en = 1'b0;
    bus.acc_clr = 1'b0; bus.signed_mode = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_reset_state();
    @(negedge clk) rst = 1'b0;

    issue(8'd13, 8'd11, 1'b0, 1'b0, 1'b0, 16'h008F, 20'd0, 1'b0, 1'b1);
    complete();
    issue(8'd255, 8'd255, 1'b0, 1'b0, 1'b0, 16'hFE01, 20'd0, 1'b0, 1'b1);
    complete();
    issue(8'd0, 8'd200, 1'b0, 1'b0, 1'b0, 16'h0000, 20'd0, 1'b0, 1'b1);
    complete();

    pulse_clr();
    issue(8'd3, 8'd4, 1'b1, 1'b0, 1'b0, 16'd12, 20'd12, 1'b0, 1'b1);
    complete();
    issue(8'd5, 8'd6, 1'b1, 1'b0, 1'b0, 16'd30, 20'd42, 1'b0, 1'b1);
    complete();
    issue(8'd2, 8'd2, 1'b1, 1'b1, 1'b0, 16'd4, 20'd4, 1'b0, 1'b1);
    complete();

    // Backpressure: result must hold while out_ready is low and new operands are offered.
    bus.out_ready = 1'b0;
    issue(8'd9, 8'd10, 1'b1, 1'b0, 1'b0, 16'd90, 20'd94, 1'b0, 1'b1);
    wait_valid();
    bus.a = 8'd1; bus.b = 8'd1; bus.acc_en = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_product", 32'(bus.product), 32'd90);
      chk("bp_acc", 32'(bus.acc), 32'd94);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("bp_nothing_queued", 32'(bus.busy), 32'd0);

    pulse_clr();
    for (int k = 1; k <= 17; k++) begin
      longint tot;
      tot = longint'(k) * 65025;
      issue(8'd255, 8'd255, 1'b1, 1'b0, 1'b0, 16'hFE01, 20'(tot % 1048576),
            (tot >= 1048576) ? 1'b1 : 1'b0, 1'b1);
      complete();
    end
    chk("ovf_acc_final", 32'(bus.acc), 32'd56849);
    issue(8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 16'd1, 20'd56849, 1'b1, 1'b1);
    complete();
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    pulse_clr();
    chk("clr_acc", 32'(bus.acc), 32'd0);
    chk("clr_overflow", 32'(bus.overflow), 32'd0);

    // Reset in the fourth RUN cycle discards the operation.
    issue(8'd7, 8'd9, 1'b1, 1'b0, 1'b0, 16'd0, 20'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_state();
    @(negedge clk) rst = 1'b0;
    issue(8'd7, 8'd9, 1'b0, 1'b0, 1'b0, 16'd63, 20'd0, 1'b0, 1'b1);
    complete();

`ifdef SIGNED_MODE_EN
    issue(8'hFD, 8'd5, 1'b1, 1'b0, 1'b1, 16'hFFF1, 20'hFFFF1, 1'b0, 1'b1);
    complete();
    issue(8'hF9, 8'hFA, 1'b0, 1'b0, 1'b1, 16'd42, 20'hFFFF1, 1'b0, 1'b1);
    complete();
`else
    issue(8'hFD, 8'd5, 1'b1, 1'b0, 1'b1, 16'h04F1, 20'h004F1, 1'b0, 1'b1);
    complete();
    issue(8'hF9, 8'hFA, 1'b0, 1'b0, 1'b1, 16'hF32A, 20'h004F1, 1'b0, 1'b1);
    complete();
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
